// File: rtl/fib_pkg.sv
// ============================================================================
// Module : fib_pkg
// Brief  : Shared types and default sizes for the Fibonacci scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fib_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fib_sched_if.sv
// ============================================================================
// Module : fib_sched_if
// Brief  : Request/response bundle between client logic and fib_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fib_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int N_W     = 6,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*N_W-1:0] req_n;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_ovf;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    modport master (
        output req_valid, req_n, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_n, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_id, busy
    );
endinterface

`default_nettype wire

// File: rtl/fib_rr_arb.sv
// ============================================================================
// Module : fib_rr_arb
// Brief  : Combinational round-robin grant, search starts one past ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fib_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fib_sched.sv
// ============================================================================
// Module : fib_sched
// Brief  : Round-robin shared iterative Fibonacci engine with overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fib_sched
    import fib_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_W     = DEF_N_W
) (
    input  logic          clk,
    input  logic          rst_n,
    fib_sched_if.slave    bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
    logic [N_W-1:0]    cnt_q, cnt_d, n_q, n_d;
    logic [ID_W-1:0]   id_q, id_d, ptr_q, ptr_d;

    logic [NUM_REQ-1:0] gnt_w;
    logic [ID_W-1:0]    gnt_id_w;
    logic               gnt_any_w;
    logic [WIDTH:0]     sum_w;

    fib_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt_w),
        .gnt_id  (gnt_id_w),
        .gnt_any (gnt_any_w)
    );

    assign sum_w = {1'b0, a_q} + {1'b0, b_q};

    assign bus.req_ready = (state_q == IDLE) ? gnt_w : '0;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = (state_q == DONE) ? a_q : '0;
    assign bus.rsp_ovf   = (state_q == DONE) ? a_ovf_q : 1'b0;
    assign bus.rsp_id    = (state_q == DONE) ? id_q : '0;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ovf_d = a_ovf_q;
        b_ovf_d = b_ovf_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_any_w) begin
                    n_d     = bus.req_n[int'(gnt_id_w)*N_W +: N_W];
                    id_d    = gnt_id_w;
                    ptr_d   = gnt_id_w;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d     = '0;
                b_d     = WIDTH'(1);
                a_ovf_d = 1'b0;
                b_ovf_d = 1'b0;
                cnt_d   = n_q;
                state_d = ITER;
            end
            ITER: begin
                // cnt is tested before stepping, so a zero count costs one
                // idle ITER cycle; that keeps latency at 2+n for every n.
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    a_d     = b_q;
                    b_d     = sum_w[WIDTH-1:0];
                    b_ovf_d = sum_w[WIDTH] | a_ovf_q | b_ovf_q;
                    a_ovf_d = b_ovf_q;
                    cnt_d   = cnt_q - N_W'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            cnt_q   <= '0;
            n_q     <= '0;
            id_q    <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_ovf_q <= a_ovf_d;
            b_ovf_q <= b_ovf_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fib_sched.sv
// ============================================================================
// Module : tb_fib_sched
// Brief  : Directed self-checking bench for fib_sched with hand-computed values.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fib_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int N_W     = 6;
    localparam int BOUND   = 300;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;
    logic [WIDTH-1:0] held_data;

    fib_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .N_W(N_W)) bus ();

    fib_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .N_W(N_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int id);
        int k;
        k = 0;
        while (!bus.req_ready[id] && k < BOUND) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("ready_%0d", id), 64'(bus.req_ready[id]), 64'd1);
    endtask

    task automatic wait_rsp(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.rsp_valid && cyc < BOUND);
        chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic send(input int id, input int n, output int cyc);
        bus.req_valid[id] = 1'b1;
        bus.req_n[id*N_W +: N_W] = N_W'(n);
        #1;
        wait_ready(id);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        wait_rsp($sformatf("n%0d", n), cyc);
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.req_valid = '0;
        bus.req_n     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        chk("rst_rsp_ovf",   64'(bus.rsp_ovf),   64'd0);
        chk("rst_rsp_id",    64'(bus.rsp_id),    64'd0);

        // single request, n=10
        send(0, 10, lat);
        chk("n10_lat",  64'(lat),          64'd12);
        chk("n10_data", 64'(bus.rsp_data), 64'd55);
        chk("n10_ovf",  64'(bus.rsp_ovf),  64'd0);
        chk("n10_id",   64'(bus.rsp_id),   64'd0);
        consume();
        chk("n10_idle", 64'(bus.busy), 64'd0);

        // n=0 and n=1 boundaries
        send(0, 0, lat);
        chk("n0_lat",  64'(lat),          64'd2);
        chk("n0_data", 64'(bus.rsp_data), 64'd0);
        chk("n0_ovf",  64'(bus.rsp_ovf),  64'd0);
        consume();
        send(0, 1, lat);
        chk("n1_lat",  64'(lat),          64'd3);
        chk("n1_data", 64'(bus.rsp_data), 64'd1);
        chk("n1_ovf",  64'(bus.rsp_ovf),  64'd0);
        consume();

        // width overflow edge: fib(47) fits in 32 bits, fib(48) does not
        send(0, 47, lat);
        chk("n47_data", 64'(bus.rsp_data), 64'hB11924E1);
        chk("n47_ovf",  64'(bus.rsp_ovf),  64'd0);
        consume();
        send(0, 48, lat);
        chk("n48_data", 64'(bus.rsp_data), 64'h1E8D0A40);
        chk("n48_ovf",  64'(bus.rsp_ovf),  64'd1);
        consume();
        send(0, 63, lat);
        chk("n63_ovf", 64'(bus.rsp_ovf), 64'd1);
        consume();

        // all requesters pending from reset: order 0,1,2,3,0
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) bus.req_n[i*N_W +: N_W] = N_W'(5);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            int exp_id;
            int k;
            exp_id = i % NUM_REQ;
            k = 0;
            while (bus.req_ready == '0 && k < BOUND) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk($sformatf("rr_grant%0d", i), 64'(bus.req_ready), 64'(1 << exp_id));
            @(posedge clk);
            #1;
            if (i == 4) bus.req_valid = '0;
            wait_rsp($sformatf("rr%0d", i), lat);
            chk($sformatf("rr_data%0d", i), 64'(bus.rsp_data), 64'd5);
            chk($sformatf("rr_id%0d", i),   64'(bus.rsp_id),   64'(exp_id));
            consume();
        end

        // back-pressure: hold DONE for 20 cycles with req 2 pending
        bus.rsp_ready = 1'b0;
        bus.req_n[2*N_W +: N_W] = N_W'(3);
        bus.req_valid[2] = 1'b1;
        send(1, 7, lat);
        chk("bp_data", 64'(bus.rsp_data), 64'd13);
        chk("bp_id",   64'(bus.rsp_id),   64'd1);
        held_data = bus.rsp_data;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid%0d", i), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("bp_data%0d", i),  64'(bus.rsp_data),  64'(held_data));
            chk($sformatf("bp_rdy%0d", i),   64'(bus.req_ready), 64'd0);
            chk($sformatf("bp_busy%0d", i),  64'(bus.busy),      64'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
        chk("bp_next_grant",    64'(bus.req_ready), 64'b0100);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        wait_rsp("bp_next", lat);
        chk("bp_next_data", 64'(bus.rsp_data), 64'd2);
        chk("bp_next_id",   64'(bus.rsp_id),   64'd2);
        consume();

        // asynchronous reset mid-iteration, then re-issue
        bus.req_valid[3] = 1'b1;
        bus.req_n[3*N_W +: N_W] = N_W'(30);
        #1;
        wait_ready(3);
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ar_busy_before", 64'(bus.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy",      64'(bus.busy),      64'd0);
        chk("ar_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("ar_req_ready", 64'(bus.req_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(3, 30, lat);
        chk("n30_lat",  64'(lat),          64'd32);
        chk("n30_data", 64'(bus.rsp_data), 64'd832040);
        chk("n30_ovf",  64'(bus.rsp_ovf),  64'd0);
        chk("n30_id",   64'(bus.rsp_id),   64'd3);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
